// File: rtl/bist_pkg.sv
// Shared types and default widths for the combinational equivalence BIST controller.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    localparam int N_IN_DEF   = 3;
    localparam int N_OUT_DEF  = 2;
    localparam int SETTLE_DEF = 1;

    // Settle counter width; a single-cycle settle still needs one bit to hold zero.
    function automatic int cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// N_IN-bit stimulus counter with clear/increment and an all-ones (last pattern) flag.
module bist_pattern_gen
    import bist_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            inc,
    output logic [N_IN-1:0] pattern,
    output logic            last
);

    logic [N_IN-1:0] pattern_r;

    // Pattern register; clear takes priority over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_r <= '0;
        end else if (clr) begin
            pattern_r <= '0;
        end else if (inc) begin
            pattern_r <= pattern_r + 1'b1;
        end
    end

    assign pattern = pattern_r;
    assign last    = &pattern_r;

endmodule

// File: rtl/equiv_bist_ctrl.sv
// Sweeps every input pattern into two implementations, compares their outputs and
// keeps pass/fail counts plus the first failing pattern.
module equiv_bist_ctrl
    import bist_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_OUT  = N_OUT_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_OUT-1:0] y_a,
    input  logic [N_OUT-1:0] y_b,
    output logic [N_IN-1:0]  pattern,
    output logic             busy,
    output logic             done,
    output logic [N_IN:0]    pass_count,
    output logic [N_IN:0]    fail_count,
    output logic             fail_seen,
    output logic [N_IN-1:0]  first_fail
);

    localparam int CW = cnt_width(SETTLE);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    bist_state_t     state_r;
    logic [CW-1:0]   settle_cnt_r;
    logic            busy_r;
    logic            done_r;
    logic [N_IN:0]   pass_r;
    logic [N_IN:0]   fail_r;
    logic            fail_seen_r;
    logic [N_IN-1:0] first_fail_r;
    logic [N_IN-1:0] pattern_s;
    logic            last_s;
    logic            clr_s;
    logic            inc_s;

    assign clr_s = (state_r == IDLE) && start;
    assign inc_s = (state_r == CHECK) && !last_s;

    bist_pattern_gen #(.N_IN(N_IN)) u_pattern_gen (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_s),
        .inc     (inc_s),
        .pattern (pattern_s),
        .last    (last_s)
    );

    // Sweep FSM with settle counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            settle_cnt_r <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= '0;
            fail_r       <= '0;
            fail_seen_r  <= 1'b0;
            first_fail_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        pass_r       <= '0;
                        fail_r       <= '0;
                        fail_seen_r  <= 1'b0;
                        first_fail_r <= '0;
                        settle_cnt_r <= '0;
                        busy_r       <= 1'b1;
                        state_r      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r <= CHECK;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 1'b1;
                    end
                end
                CHECK: begin
                    // An X/Z operand makes the equality unknown and lands in the mismatch branch.
                    if (y_a == y_b) begin
                        pass_r <= pass_r + 1'b1;
                    end else begin
                        fail_r <= fail_r + 1'b1;
                        if (!fail_seen_r) begin
                            fail_seen_r  <= 1'b1;
                            first_fail_r <= pattern_s;
                        end
                    end
                    if (last_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        settle_cnt_r <= '0;
                        state_r      <= DRIVE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign pattern    = pattern_s;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass_count = pass_r;
    assign fail_count = fail_r;
    assign fail_seen  = fail_seen_r;
    assign first_fail = first_fail_r;

endmodule

// File: tb/tb_equiv_bist_ctrl.sv
// Self-checking bench: golden full adder on y_a, selectable faulty model on y_b,
// expected results computed from the fault model over all patterns.
module tb_equiv_bist_ctrl;

    localparam int N_IN  = 3;
    localparam int N_OUT = 2;
    localparam int NPAT  = 1 << N_IN;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             start      [2];
    logic             reset      [2];
    logic [N_OUT-1:0] ya         [2];
    logic [N_OUT-1:0] yb         [2];
    logic [N_IN-1:0]  pattern    [2];
    logic             busy       [2];
    logic             done       [2];
    logic [N_IN:0]    pass_count [2];
    logic [N_IN:0]    fail_count [2];
    logic             fail_seen  [2];
    logic [N_IN-1:0]  first_fail [2];
    int               mode       [2];
    logic [15:0]      mask       [2];

    int checks = 0;
    int errors = 0;

    // Full adder {a,b,c}: output {carry,sum} is simply the number of ones.
    function automatic logic [1:0] golden(input logic [2:0] p);
        int s;
        s = int'(p[0]) + int'(p[1]) + int'(p[2]);
        return s[1:0];
    endfunction

    // 0 identical, 1 carry stuck-at-0, 2 sum inverted at pattern 5, 3 random xor mask.
    function automatic logic [1:0] model_b(input int md, input logic [2:0] p, input logic [15:0] m);
        logic [1:0] g;
        g = golden(p);
        case (md)
            1: return {1'b0, g[0]};
            2: return (p == 3'd5) ? {g[1], ~g[0]} : g;
            3: return g ^ m[2*int'(p) +: 2];
            default: return g;
        endcase
    endfunction

    assign ya[0] = golden(pattern[0]);
    assign yb[0] = model_b(mode[0], pattern[0], mask[0]);
    assign ya[1] = golden(pattern[1]);
    assign yb[1] = model_b(mode[1], pattern[1], mask[1]);

    equiv_bist_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1)) dut0 (
        .clk(clk), .reset(reset[0]), .start(start[0]), .y_a(ya[0]), .y_b(yb[0]),
        .pattern(pattern[0]), .busy(busy[0]), .done(done[0]),
        .pass_count(pass_count[0]), .fail_count(fail_count[0]),
        .fail_seen(fail_seen[0]), .first_fail(first_fail[0])
    );

    equiv_bist_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(3)) dut1 (
        .clk(clk), .reset(reset[1]), .start(start[1]), .y_a(ya[1]), .y_b(yb[1]),
        .pattern(pattern[1]), .busy(busy[1]), .done(done[1]),
        .pass_count(pass_count[1]), .fail_count(fail_count[1]),
        .fail_seen(fail_seen[1]), .first_fail(first_fail[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input int sel, input string tag);
        check({tag, "_pattern"}, 32'(pattern[sel]), 32'd0);
        check({tag, "_busy"}, 32'(busy[sel]), 32'd0);
        check({tag, "_done"}, 32'(done[sel]), 32'd0);
        check({tag, "_pass"}, 32'(pass_count[sel]), 32'd0);
        check({tag, "_fail"}, 32'(fail_count[sel]), 32'd0);
        check({tag, "_seen"}, 32'(fail_seen[sel]), 32'd0);
        check({tag, "_first"}, 32'(first_fail[sel]), 32'd0);
    endtask

    // smode: 0 one-cycle start pulse, 1 start left high, 2 random start noise while busy.
    task automatic sweep(input int sel, input int settle, input int smode, input string tag);
        int         per;
        int         total;
        int         ep;
        int         ef;
        logic [2:0] efirst;
        per    = settle + 1;
        total  = NPAT * per;
        ep     = 0;
        ef     = 0;
        efirst = 3'd0;
        for (int p = 0; p < NPAT; p++) begin
            if (model_b(mode[sel], 3'(p), mask[sel]) != golden(3'(p))) begin
                if (ef == 0) efirst = 3'(p);
                ef++;
            end else begin
                ep++;
            end
        end
        start[sel] = 1'b1;
        @(negedge clk);
        check({tag, "_clr_pass"}, 32'(pass_count[sel]), 32'd0);
        check({tag, "_clr_fail"}, 32'(fail_count[sel]), 32'd0);
        check({tag, "_clr_seen"}, 32'(fail_seen[sel]), 32'd0);
        check({tag, "_clr_first"}, 32'(first_fail[sel]), 32'd0);
        for (int c = 0; c < total; c++) begin
            check({tag, "_busy"}, 32'(busy[sel]), 32'd1);
            check({tag, "_nodone"}, 32'(done[sel]), 32'd0);
            check({tag, "_pattern"}, 32'(pattern[sel]), 32'(c / per));
            if (smode == 0) start[sel] = 1'b0;
            else if (smode == 2) start[sel] = (c < total - 1) ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(done[sel]), 32'd1);
        check({tag, "_done_busy"}, 32'(busy[sel]), 32'd0);
        check({tag, "_end_pattern"}, 32'(pattern[sel]), 32'(NPAT - 1));
        check({tag, "_pass"}, 32'(pass_count[sel]), 32'(ep));
        check({tag, "_fail"}, 32'(fail_count[sel]), 32'(ef));
        check({tag, "_seen"}, 32'(fail_seen[sel]), 32'(ef != 0));
        check({tag, "_first"}, 32'(first_fail[sel]), 32'(efirst));
        @(negedge clk);
        check({tag, "_idle_done"}, 32'(done[sel]), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy[sel]), 32'd0);
        check({tag, "_hold_pass"}, 32'(pass_count[sel]), 32'(ep));
        if (smode != 1) begin
            @(negedge clk);
            check({tag, "_stay_idle"}, 32'(busy[sel]), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            reset[i] = 1'b1;
            mode[i]  = 0;
            mask[i]  = 16'd0;
        end
        repeat (2) @(negedge clk);
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        check_zero(0, "reset0");
        check_zero(1, "reset1");

        // Identical adders.
        sweep(0, 1, 0, "t1");
        check("t1_spec_pass", 32'(pass_count[0]), 32'd8);

        // Carry stuck-at-0 fails wherever two or more inputs are set.
        mode[0] = 1;
        sweep(0, 1, 0, "t2");
        check("t2_spec_fail", 32'(fail_count[0]), 32'd4);
        check("t2_spec_first", 32'(first_fail[0]), 32'd3);

        // Sum inverted only at pattern 5.
        mode[0] = 2;
        sweep(0, 1, 0, "t3");
        check("t3_spec_pass", 32'(pass_count[0]), 32'd7);
        check("t3_spec_first", 32'(first_fail[0]), 32'd5);

        // Reset in DRIVE of pattern 4, then a clean sweep.
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("t4_pre_pattern", 32'(pattern[0]), 32'd4);
        check("t4_pre_pass", 32'(pass_count[0]), 32'd4);
        reset[0] = 1'b1;
        @(negedge clk);
        reset[0] = 1'b0;
        check_zero(0, "t4_reset");
        @(negedge clk);
        check_zero(0, "t4_idle");
        mode[0] = 0;
        sweep(0, 1, 0, "t4_clean");

        // Start held high: automatic restart with cleared counts; start noise ignored.
        mode[0] = 2;
        sweep(0, 1, 1, "t5a");
        mode[0] = 1;
        sweep(0, 1, 2, "t5b");

        // Randomised fault masks and start styles.
        repeat (4) begin
            mode[0] = 3;
            mask[0] = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sweep(0, 1, 2 * int'($urandom_range(0, 1)), "rnd0");
        end

        // SETTLE=3 instance: each pattern held four cycles.
        sweep(1, 3, 0, "t6");
        check("t6_spec_pass", 32'(pass_count[1]), 32'd8);
        mode[1] = 3;
        mask[1] = 16'($urandom);
        sweep(1, 3, 2, "rnd1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
